// File: rtl/core_seq_ctrl.sv
// Sequencer for one full WS convolution pass on core: core reset, weight load,
// activation feed and psum drain per kij, then readout. TILE2_EN doubles the weight-load beats.
module core_seq_ctrl #(
  parameter int COL     = 8,
  parameter int LEN_NIJ = 36,
  parameter int LEN_KIJ = 9,
  parameter int RST_CYC = 10,
  parameter int DRAIN   = 30,
  parameter int W_BASE  = 1024,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              core_rst,
  output logic [1:0]        inst_w,
  output logic              CEN_xmem,
  output logic              WEN_xmem,
  output logic [ADDR_W-1:0] A_xmem,
  output logic [3:0]        kij,
  output logic              readout_start,
  output logic [3:0]        dbg_state
);

`ifdef TILE2_EN
  localparam int NW = 2 * COL;
`else
  localparam int NW = COL;
`endif

  localparam int CMAX_A = (RST_CYC > DRAIN) ? RST_CYC : DRAIN;
  localparam int CMAX_B = (NW > LEN_NIJ) ? NW : LEN_NIJ;
  localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0]     C_RST   = CW'(RST_CYC);
  localparam logic [CW-1:0]     C_DRAIN = CW'(DRAIN);
  localparam logic [CW-1:0]     C_NW    = CW'(NW);
  localparam logic [CW-1:0]     C_NIJ   = CW'(LEN_NIJ);
  localparam logic [CW-1:0]     C_ONE   = CW'(1);
  localparam logic [3:0]        K_LAST  = 4'(LEN_KIJ - 1);
  localparam logic [ADDR_W-1:0] A_WBASE = ADDR_W'(W_BASE);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CRST  = 4'd1;
  localparam logic [3:0] S_CGAP  = 4'd2;
  localparam logic [3:0] S_WLOAD = 4'd3;
  localparam logic [3:0] S_WGAP  = 4'd4;
  localparam logic [3:0] S_AFEED = 4'd5;
  localparam logic [3:0] S_DRAIN = 4'd6;
  localparam logic [3:0] S_RDOUT = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  // Handshake: stall is a level back-pressure input sampled on each rising edge;
  // while high in WLOAD/AFEED the next cycle is a bubble and the pending beat waits.
  logic [3:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, pend;
  logic              bub_q, bub_d;
  logic [3:0]        kij_q, kij_d;
  logic              busy_q, busy_d, done_q, done_d, core_rst_q, core_rst_d;
  logic [1:0]        inst_w_q, inst_w_d;
  logic              cen_q, cen_d, rdst_q, rdst_d, feed;
  logic [ADDR_W-1:0] a_q, a_d;

  // In feed states cnt_q is the beat shown this cycle unless bub_q marks a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bub_d   = 1'b0;
    kij_d   = kij_q;
    pend    = bub_q ? cnt_q : cnt_q + C_ONE;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CRST;
        cnt_d   = '0;
        kij_d   = '0;
      end
      S_CRST: if (cnt_q == C_RST) begin
        state_d = S_CGAP;
        cnt_d   = '0;
      end else cnt_d = cnt_q + C_ONE;
      S_CGAP: if (cnt_q == C_ONE) begin
        state_d = S_WLOAD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + C_ONE;
      S_WLOAD: if (pend == C_NW) begin
        state_d = S_WGAP;
        cnt_d   = '0;
      end else begin
        cnt_d = pend;
        bub_d = stall;
      end
      S_WGAP: begin
        state_d = S_AFEED;
        cnt_d   = '0;
      end
      S_AFEED: if (pend == C_NIJ) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end else begin
        cnt_d = pend;
        bub_d = stall;
      end
      S_DRAIN: if (cnt_q == C_DRAIN) begin
        cnt_d = '0;
        if (kij_q == K_LAST) state_d = S_RDOUT;
        else begin
          state_d = S_CRST;
          kij_d   = kij_q + 4'd1;
        end
      end else cnt_d = cnt_q + C_ONE;
      S_RDOUT: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    feed       = ((state_d == S_WLOAD) || (state_d == S_AFEED)) && !bub_d;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    core_rst_d = (state_d == S_CRST);
    rdst_d     = (state_d == S_RDOUT);
    cen_d      = !feed;
    inst_w_d   = 2'b00;
    a_d        = '0;
    if (feed) begin
      if (state_d == S_WLOAD) begin
        inst_w_d = 2'b01;
        a_d      = A_WBASE + ADDR_W'(cnt_d);
      end else begin
        inst_w_d = 2'b10;
        a_d      = ADDR_W'(cnt_d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bub_q      <= 1'b0;
      kij_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b0;
      inst_w_q   <= 2'b00;
      cen_q      <= 1'b1;
      a_q        <= '0;
      rdst_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bub_q      <= bub_d;
      kij_q      <= kij_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
      inst_w_q   <= inst_w_d;
      cen_q      <= cen_d;
      a_q        <= a_d;
      rdst_q     <= rdst_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign core_rst      = core_rst_q;
  assign inst_w        = inst_w_q;
  assign CEN_xmem      = cen_q;
  assign WEN_xmem      = 1'b1;
  assign A_xmem        = a_q;
  assign kij           = kij_q;
  assign readout_start = rdst_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: feed-beat scoreboard plus pass timing, stall,
// ignored-start and abort scenarios. Honours TILE2_EN like the design.
module tb_core_seq_ctrl;

  localparam int COL     = 8;
  localparam int LEN_NIJ = 36;
  localparam int LEN_KIJ = 9;
  localparam int RST_CYC = 10;
  localparam int DRAIN   = 30;
  localparam int W_BASE  = 1024;
  localparam int ADDR_W  = 11;
`ifdef TILE2_EN
  localparam int NW = 2 * COL;
`else
  localparam int NW = COL;
`endif
  localparam int PERIOD = (RST_CYC + 1) + 2 + NW + 1 + LEN_NIJ + (DRAIN + 1);
  localparam int W      = 2 + ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              busy, done, core_rst, CEN_xmem, WEN_xmem, readout_start;
  logic [1:0]        inst_w;
  logic [ADDR_W-1:0] A_xmem;
  logic [3:0]        kij, dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  core_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .core_rst(core_rst), .inst_w(inst_w),
    .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .A_xmem(A_xmem), .kij(kij),
    .readout_start(readout_start), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_core_rst"}, 32'(core_rst), 0);
    chk({pfx, "_inst_w"}, 32'(inst_w), 0);
    chk({pfx, "_cen"}, 32'(CEN_xmem), 1);
    chk({pfx, "_wen"}, 32'(WEN_xmem), 1);
    chk({pfx, "_addr"}, 32'(A_xmem), 0);
    chk({pfx, "_kij"}, 32'(kij), 0);
    chk({pfx, "_rdst"}, 32'(readout_start), 0);
  endtask

  // One pass. do_stall: 3-cycle stall at AFEED beat 5 of kij 0 (plus a stall in CRST
  // that must be ignored). do_ign: start pulses that must be ignored. abort_at: reset cycle.
  task automatic run_pass(input bit do_stall, input bit do_ign, input int abort_at);
    int extra    = do_stall ? 3 : 0;
    int rd_exp   = LEN_KIJ * PERIOD + 1 + extra;
    int done_exp = rd_exp + 1;
    int rd_cyc = -1, rd_cnt = 0, done_cyc = -1, done_cnt = 0;
    int crst_cyc = 0, win = 0, bad_idle = 0, wen_bad = 0, stall_left = 0;
    int a4_cyc = -1, a5_cyc = -1;
    bit prev_crst = 1'b0, stalled = 1'b0, scoring;
    logic [W-1:0] obs;
    scoring = (abort_at == 0);
    if (scoring)
      for (int k = 0; k < LEN_KIJ; k++) begin
        for (int t = 0; t < NW; t++) exp_q.push_back({2'b01, ADDR_W'(W_BASE + t)});
        for (int t = 0; t < LEN_NIJ; t++) exp_q.push_back({2'b10, ADDR_W'(t)});
      end
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= done_exp + 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        reset = 1'b0;
        #1;
        chk_reset_vals("abort");
        chk("abort_no_done", 32'(done_cnt), 0);
        break;
      end
      if (k == 1) begin
        chk("first_busy", 32'(busy), 1);
        chk("first_core_rst", 32'(core_rst), 1);
      end
      if (do_ign) begin
        if (k == 100 || k == done_exp) start = 1'b1;
        if (k == 101 || k == done_exp + 1) start = 1'b0;
      end
      if (do_stall) begin
        if (k == 1) stall = 1'b1;
        if (k == 6) stall = 1'b0;
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) stall = 1'b0;
        end
      end
      if (WEN_xmem !== 1'b1) wen_bad++;
      if (CEN_xmem === 1'b0) begin
        obs = {inst_w, A_xmem};
        if (win == 1 && inst_w == 2'b10 && A_xmem == 4) a4_cyc = k;
        if (win == 1 && inst_w == 2'b10 && A_xmem == 5) a5_cyc = k;
        if (do_stall && !stalled && win == 1 && inst_w == 2'b10 && A_xmem == 4) begin
          stalled    = 1'b1;
          stall      = 1'b1;
          stall_left = 3;
        end
        if (scoring) begin
          if (exp_q.size() == 0) chk("beat_extra", 32'(obs), 0);
          else chk("beat", 32'(obs), 32'(exp_q.pop_front()));
        end
      end else if (inst_w !== 2'b00 || A_xmem !== '0) bad_idle++;
      if (core_rst === 1'b1) begin
        crst_cyc++;
        if (!prev_crst) begin
          chk("kij_window", 32'(kij), 32'(win));
          win++;
        end
      end
      prev_crst = (core_rst === 1'b1);
      if (readout_start === 1'b1) begin
        rd_cnt++;
        rd_cyc = k;
        chk("rdout_busy", 32'(busy), 1);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
        chk("done_busy", 32'(busy), 0);
      end
    end
    stall = 1'b0;
    start = 1'b0;
    if (abort_at != 0) begin
      repeat (2) @(negedge clk);
      chk_reset_vals("abort_hold");
      reset = 1'b1;
      @(negedge clk);
      chk("post_abort_busy", 32'(busy), 0);
      return;
    end
    chk("rdout_cycle", 32'(rd_cyc), 32'(rd_exp));
    chk("rdout_count", 32'(rd_cnt), 1);
    chk("done_cycle", 32'(done_cyc), 32'(done_exp));
    chk("done_count", 32'(done_cnt), 1);
    chk("crst_windows", 32'(win), 32'(LEN_KIJ));
    chk("crst_cycles", 32'(crst_cyc), 32'(LEN_KIJ * (RST_CYC + 1)));
    chk("kij_final", 32'(kij), 32'(LEN_KIJ - 1));
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("idle_ctrl_bad", 32'(bad_idle), 0);
    chk("wen_bad", 32'(wen_bad), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_core_rst", 32'(core_rst), 0);
    chk("beat4_to_beat5", 32'(a5_cyc - a4_cyc), do_stall ? 32'd4 : 32'd1);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);
    run_pass(1'b0, 1'b0, 0);
    run_pass(1'b1, 1'b0, 0);
    run_pass(1'b0, 1'b1, 0);
    run_pass(1'b0, 1'b0, 400);
    run_pass(1'b0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
